// File: rtl/vga_rx_capture.sv
// VGA receive front end: samples sync/red pins, recovers pixel
// coordinates, checks line/frame timing and reports lock.
module vga_rx_capture #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FRONT     = 16,
  parameter int H_PULSE     = 96,
  parameter int H_BACK      = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FRONT     = 10,
  parameter int V_PULSE     = 2,
  parameter int V_BACK      = 33,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clock_25,
  input  logic       rst,
  input  logic       vga_hsync,
  input  logic       vga_vsync,
  input  logic [7:0] vga_red,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic [7:0] pix_data,
  output logic       pix_valid,
  output logic       frame_start,
  output logic       h_err,
  output logic       v_err,
  output logic       locked
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_PULSE + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_PULSE + V_BACK;

  localparam logic [9:0] HB1   = 10'(H_BACK - 1);
  localparam logic [9:0] HA1   = 10'(H_ACTIVE - 1);
  localparam logic [9:0] HTOT  = 10'(H_TOTAL);
  localparam logic [9:0] HPW   = 10'(H_PULSE);
  localparam logic [9:0] VB    = 10'(V_BACK);
  localparam logic [9:0] VEND  = 10'(V_BACK + V_ACTIVE);
  localparam logic [9:0] VLAST = 10'(V_TOTAL - 1);
  localparam logic [3:0] LOCKN = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    S_WAIT, S_BACK, S_ACT, S_BLANK
  } h_state_t;

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == 10'h3ff) ? v : v + 10'd1;
  endfunction

  logic       hs_q, vs_q, hs_p, vs_p;
  logic [7:0] red_q, red_a;
  logic       hrise, vrise;

  h_state_t   h_st;
  logic [9:0] hcnt, per_cnt, lo_cnt, line;
  logic       v_ok;
  logic       herr_a, verr_a, vdone_a, vrise_a;

  logic [3:0] lock_cnt, cnt_nxt;
  logic       dirty, act, err;

  assign hrise = hs_q & ~hs_p;
  assign vrise = vs_q & ~vs_p;

  // pin registers; syncs idle high so a rise needs a real low sample
  always_ff @(posedge clock_25 or negedge rst) begin
    if (!rst) begin
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      hs_p  <= 1'b1;
      vs_p  <= 1'b1;
      red_q <= '0;
    end else begin
      hs_q  <= vga_hsync;
      vs_q  <= vga_vsync;
      hs_p  <= hs_q;
      vs_p  <= vs_q;
      red_q <= vga_red;
    end
  end

  always_ff @(posedge clock_25 or negedge rst) begin
    if (!rst) begin
      h_st    <= S_WAIT;
      hcnt    <= '0;
      per_cnt <= '0;
      lo_cnt  <= '0;
      line    <= '0;
      v_ok    <= 1'b0;
      red_a   <= '0;
      herr_a  <= 1'b0;
      verr_a  <= 1'b0;
      vdone_a <= 1'b0;
      vrise_a <= 1'b0;
    end else begin
      red_a   <= red_q;
      lo_cnt  <= hs_q ? 10'd0 : sat_inc(lo_cnt);
      herr_a  <= hrise && (h_st != S_WAIT) &&
                 (per_cnt != HTOT || lo_cnt != HPW);
      verr_a  <= vrise && v_ok && (line != VLAST);
      vdone_a <= vrise && v_ok;
      vrise_a <= vrise;
      v_ok    <= v_ok | vrise;
      if (vrise)
        line <= '0;
      else if (hrise)
        line <= sat_inc(line);
      if (hrise) begin
        h_st    <= S_BACK;
        hcnt    <= '0;
        per_cnt <= 10'd1;
      end else begin
        per_cnt <= sat_inc(per_cnt);
        unique case (h_st)
          S_BACK: begin
            if (hcnt == HB1) begin
              h_st <= S_ACT;
              hcnt <= '0;
            end else begin
              hcnt <= hcnt + 10'd1;
            end
          end
          S_ACT: begin
            if (hcnt == HA1) begin
              h_st <= S_BLANK;
              hcnt <= '0;
            end else begin
              hcnt <= hcnt + 10'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign act = (h_st == S_ACT) && v_ok &&
               (line >= VB) && (line < VEND);
  assign err = herr_a | verr_a;
  assign cnt_nxt = (lock_cnt == 4'hf) ? lock_cnt
                                      : lock_cnt + 4'd1;

  // an error always beats a simultaneous frame completion
  always_ff @(posedge clock_25 or negedge rst) begin
    if (!rst) begin
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_data    <= '0;
      frame_start <= 1'b0;
      h_err       <= 1'b0;
      v_err       <= 1'b0;
      locked      <= 1'b0;
      lock_cnt    <= '0;
      dirty       <= 1'b0;
    end else begin
      pix_valid   <= act;
      pix_x       <= act ? hcnt : 10'd0;
      pix_y       <= act ? line - VB : 10'd0;
      pix_data    <= act ? red_a : 8'd0;
      frame_start <= act && (hcnt == '0) && (line == VB);
      h_err       <= herr_a;
      v_err       <= verr_a;
      if (err) begin
        lock_cnt <= '0;
        locked   <= 1'b0;
        dirty    <= ~vrise_a;
      end else if (vrise_a) begin
        dirty <= 1'b0;
        if (vdone_a && !dirty) begin
          lock_cnt <= cnt_nxt;
          if (cnt_nxt >= LOCKN)
            locked <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_rx_capture.sv
// Scoreboard bench for vga_rx_capture on a reduced 8x4 raster.
// Generator pushes expected pixels/events; a monitor pops and compares.
module tb_vga_rx_capture;

  localparam int HA = 8, HF = 2, HP = 3, HB = 2;
  localparam int VA = 4, VF = 2, VP = 2, VB = 2;
  localparam int HT = HA + HF + HP + HB;
  localparam int VT = VA + VF + VP + VB;

  logic       clock_25 = 1'b0;
  logic       rst = 1'b0;
  logic       vga_hsync = 1'b1;
  logic       vga_vsync = 1'b1;
  logic [7:0] vga_red = '0;
  logic [9:0] pix_x, pix_y;
  logic [7:0] pix_data;
  logic       pix_valid, frame_start, h_err, v_err, locked;

  vga_rx_capture #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_PULSE(HP), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_PULSE(VP), .V_BACK(VB),
    .LOCK_FRAMES(2)
  ) dut (
    .clock_25(clock_25), .rst(rst),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
    .vga_red(vga_red),
    .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
    .pix_valid(pix_valid), .frame_start(frame_start),
    .h_err(h_err), .v_err(v_err), .locked(locked)
  );

  always #20 clock_25 = ~clock_25;

  int cyc = 0;
  always @(posedge clock_25) cyc <= cyc + 1;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] d;
    logic       fs;
  } px_t;

  px_t px_q[$];
  int  herr_q[$], verr_q[$], lock_q[$];
  int  tests = 0, fails = 0;
  bit  pix_en = 0;
  int  frame_no = 0;
  int  rcnt = 0;

  px_t  e;
  int   t_exp;
  logic locked_prev = 1'b0;

  always @(negedge clock_25) begin
    if (!rst) begin
      locked_prev <= 1'b0;
    end else begin
      tests++;
      if (pix_valid) begin
        if (px_q.size() == 0) begin
          fails++;
          $display("FAIL pix_extra cyc=%0d got x=%0d y=%0d",
                   cyc, pix_x, pix_y);
        end else begin
          e = px_q.pop_front();
          if ({pix_x, pix_y, pix_data, frame_start} != e) begin
            fails++;
            $display("FAIL pix cyc=%0d got x=%0d y=%0d d=%0d fs=%0b want x=%0d y=%0d d=%0d fs=%0b",
                     cyc, pix_x, pix_y, pix_data, frame_start,
                     e.x, e.y, e.d, e.fs);
          end
        end
      end else if ({pix_x, pix_y, pix_data, frame_start} != '0) begin
        fails++;
        $display("FAIL pix_idle cyc=%0d got x=%0d y=%0d d=%0d fs=%0b want 0",
                 cyc, pix_x, pix_y, pix_data, frame_start);
      end
      if (h_err) begin
        tests++;
        t_exp = (herr_q.size() != 0) ? herr_q.pop_front() : -1;
        if (t_exp != cyc) begin
          fails++;
          $display("FAIL h_err got cyc=%0d want cyc=%0d", cyc, t_exp);
        end
      end
      if (v_err) begin
        tests++;
        t_exp = (verr_q.size() != 0) ? verr_q.pop_front() : -1;
        if (t_exp != cyc) begin
          fails++;
          $display("FAIL v_err got cyc=%0d want cyc=%0d", cyc, t_exp);
        end
      end
      if ((h_err || v_err) && locked) begin
        fails++;
        $display("FAIL lock_clear cyc=%0d got locked=1 want 0", cyc);
      end
      if (locked && !locked_prev) begin
        tests++;
        t_exp = (lock_q.size() != 0) ? lock_q.pop_front() : -1;
        if (t_exp != cyc) begin
          fails++;
          $display("FAIL lock_rise got cyc=%0d want cyc=%0d", cyc, t_exp);
        end
      end
      if (!locked && locked_prev && !(h_err || v_err)) begin
        fails++;
        $display("FAIL lock_drop cyc=%0d got drop without error", cyc);
      end
      locked_prev <= locked;
    end
  end

  task automatic check_zero(input string tag);
    tests++;
    if ({pix_x, pix_y, pix_data, pix_valid, frame_start,
         h_err, v_err, locked} != '0) begin
      fails++;
      $display("FAIL %s got x=%0d y=%0d d=%0d v=%0b fs=%0b he=%0b ve=%0b lk=%0b want 0",
               tag, pix_x, pix_y, pix_data, pix_valid, frame_start,
               h_err, v_err, locked);
    end
  endtask

  // kind: 0 normal, 1 stretched line, 2 narrow pulse, 3 long hsync hold
  task automatic frame(input int nl, input int mline, input int kind,
                       input bit herr0, input bit verr0,
                       input bit lock0, input int rline);
    int len, pw;
    logic hs, vs;
    logic [7:0] red;
    px_t p;
    for (int j = 0; j < nl; j++) begin
      len = HT;
      pw  = HP;
      if (j == mline && kind == 1) len = HT + 1;
      if (j == mline && kind == 2) pw = HP - 1;
      if (j == mline && kind == 3) begin
        len = HT - HP + 2000;
        pw  = 2000;
      end
      for (int c = 0; c < len; c++) begin
        hs  = (c < len - pw);
        vs  = (j < nl - VP);
        red = 8'(j * 16 + c + frame_no * 37);
        @(negedge clock_25);
        vga_hsync = hs;
        vga_vsync = vs;
        vga_red   = red;
        if (c == 0) begin
          if ((j == 0 && herr0) ||
              (j == mline + 1 && (kind == 1 || kind == 2)))
            herr_q.push_back(cyc + 3);
          if (j == 0 && verr0) verr_q.push_back(cyc + 3);
          if (j == 0 && lock0) lock_q.push_back(cyc + 3);
        end
        if (pix_en && j >= VB && j < VB + VA &&
            c >= HB && c < HB + HA) begin
          p.x  = 10'(c - HB);
          p.y  = 10'(j - VB);
          p.d  = red;
          p.fs = (c == HB && j == VB);
          px_q.push_back(p);
        end
        if (j == rline && c == 3) begin
          @(posedge clock_25);
          #2 rst = 1'b0;
          pix_en = 0;
          rcnt = 10;
          px_q.delete();
        end else if (rcnt > 0) begin
          rcnt--;
          if (rcnt == 5) check_zero("reset_mid");
          if (rcnt == 0) begin
            @(posedge clock_25);
            #2 rst = 1'b1;
          end
        end
      end
    end
    frame_no++;
  endtask

  task automatic empty_check(input string tag, input int n);
    tests++;
    if (n != 0) begin
      fails++;
      $display("FAIL %s got %0d pending want 0", tag, n);
    end
  endtask

  initial begin
    repeat (3) @(negedge clock_25);
    check_zero("reset_init");
    @(posedge clock_25);
    #2 rst = 1'b1;

    // clean stream; lock on 3rd vsync rise
    pix_en = 0;
    frame(VT, -1, 0, 0, 0, 0, -1);
    pix_en = 1;
    frame(VT, -1, 0, 0, 0, 0, -1);
    frame(VT, -1, 0, 0, 0, 0, -1);
    frame(VT, -1, 0, 0, 0, 1, -1);
    frame(VT, -1, 0, 0, 0, 0, -1);
    // stretched line
    frame(VT, 3, 1, 0, 0, 0, -1);
    frame(VT, -1, 0, 0, 0, 0, -1);
    frame(VT, -1, 0, 0, 0, 0, -1);
    // narrow hsync pulse
    frame(VT, 2, 2, 0, 0, 1, -1);
    frame(VT, -1, 0, 0, 0, 0, -1);
    frame(VT, -1, 0, 0, 0, 0, -1);
    // one line short frame
    frame(VT - 1, -1, 0, 0, 0, 1, -1);
    frame(VT, -1, 0, 0, 1, 0, -1);
    // hsync held low across the last line
    frame(VT, -1, 0, 0, 0, 0, -1);
    frame(VT, VT - 1, 3, 0, 0, 1, -1);
    frame(VT, -1, 0, 1, 0, 0, -1);
    frame(VT, -1, 0, 0, 0, 0, -1);
    // reset mid-frame
    frame(VT, -1, 0, 0, 0, 1, -1);
    frame(VT, -1, 0, 0, 0, 0, VB + 1);
    pix_en = 1;
    frame(VT, -1, 0, 0, 0, 0, -1);
    frame(VT, -1, 0, 0, 0, 0, -1);
    frame(VT, -1, 0, 0, 0, 1, -1);
    frame(VT, -1, 0, 0, 0, 0, -1);

    repeat (6) begin
      @(negedge clock_25);
      vga_hsync = 1'b1;
      vga_vsync = 1'b1;
    end
    empty_check("pix_missing", px_q.size());
    empty_check("h_err_missing", herr_q.size());
    empty_check("v_err_missing", verr_q.size());
    empty_check("lock_missing", lock_q.size());

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_rx_capture.md
Name: vga_rx_capture

Overview:
- Receive-side counterpart of the team's VGA timing generator. Samples the sync and red-channel pins on the pixel clock and recovers pixel coordinates from sync edges and porch counts.
- Checks line and frame timing against the parameters and reports lock.
- Used in loopback verification of the generator, and as the front end for frame capture and checksum logic.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (cycles)
- H_PULSE, 96, hsync low width (cycles)
- H_BACK, 48, horizontal back porch (cycles)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_PULSE, 2, vsync low width (lines)
- V_BACK, 33, vertical back porch (lines)
- LOCK_FRAMES, 2, consecutive error-free frames required for lock (1..15)
- Derived: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525).

Ports:
- clock_25  in  1  pixel clock; all inputs are synchronous to it
- rst  in  1  asynchronous active-low reset
- vga_hsync  in  1  horizontal sync, active low
- vga_vsync  in  1  vertical sync, active low
- vga_red  in  8  pixel data
- pix_x  out  10  column of the current output pixel
- pix_y  out  10  row of the current output pixel
- pix_data  out  8  captured pixel
- pix_valid  out  1  output pixel is in the active area
- frame_start  out  1  pulse marking the pixel at (0,0)
- h_err  out  1  one-cycle pulse: bad line timing
- v_err  out  1  one-cycle pulse: bad frame timing
- locked  out  1  timing stable for LOCK_FRAMES frames

Behaviour:
- Pin sampling:
  - Pins are registered once. Sync registers reset to 1, so a rise requires a sampled 0 followed by a sampled 1.
  - Sample k means the pin values at clock edge k.
- Hsync rise at sample r (hsync 0 at r-1, 1 at r) starts a line.
  - Samples r+H_BACK .. r+H_BACK+H_ACTIVE-1 are active columns x = 0..H_ACTIVE-1.
  - All other samples are blank.
- Line counter L:
  - A vsync rise at sample q sets L = 0.
  - Each hsync rise at a sample later than q increments L. An hsync rise coincident with q is not counted.
  - Lines with L in [V_BACK, V_BACK+V_ACTIVE-1] are active, with y = L - V_BACK.
  - L saturates at 1023.
- Horizontal tracking states:
  - H_WAIT (reset): until the first hsync rise.
  - H_BACK
  - H_ACTIVE
  - H_BLANK: front porch plus sync pulse, until the next hsync rise.
  - An hsync rise in any state forces H_BACK with the cycle count restarted. A short line truncates the active area.
- Vertical tracking is invalid from reset until the first vsync rise.
- Output timing:
  - All outputs are registered. Latency is 2 cycles: the result for sample k is visible after edge k+2.
  - pix_valid = 1 only when horizontal and vertical tracking are both established and (x,y) is active. pix_x, pix_y and pix_data hold that pixel.
  - When pix_valid = 0: pix_x, pix_y and pix_data are 0.
  - frame_start = pix_valid AND x = 0 AND y = 0.
- Line checks:
  - The period counter counts samples between consecutive hsync rises and saturates at 1023.
  - The low-width counter counts consecutive hsync-low samples.
  - At every hsync rise except the first after reset: h_err pulses if period ≠ H_TOTAL or low width ≠ H_PULSE.
- Frame check: at every vsync rise except the first after reset, v_err pulses if L ≠ V_TOTAL-1.
- Lock:
  - A 4-bit counter counts frames completed (vsync rise to vsync rise) with no h_err and no v_err.
  - locked rises in the cycle the counter reaches LOCK_FRAMES.
  - Any h_err or v_err clears both the counter and locked in the same cycle the pulse is output. The error wins over a simultaneous frame completion.
  - The partial frame before the first vsync rise never counts.
- Reset values: every output is 0; all FSMs return to wait states. An asynchronous reset mid-frame restarts acquisition from scratch, with no error pulses caused by the truncated frame.
- Arithmetic: all counters are 10-bit saturating. Nothing wraps to 0 except through a sync rise.

Test Plan:
1. Clean 640x480 stream, vga_red = x[7:0], 4 frames:
   - pix_valid high exactly 640 cycles per active line, 307200 per frame.
   - pix_x = 0..639 and pix_data = pix_x[7:0].
   - frame_start once per frame from the second vsync rise onward.
   - locked rises 2 cycles after the 3rd vsync-rise sample.
   - No h_err or v_err.
2. Locked stream, one line stretched to 801 cycles:
   - Single h_err pulse 2 cycles after the late hsync-rise sample; locked drops in the same cycle.
   - locked reasserts after 2 further clean frames.
3. Locked stream, one hsync pulse 95 cycles wide with period kept at 800: h_err once, locked drops.
4. Frame of 524 lines: v_err at the next vsync rise, no h_err, locked = 0.
5. rst asserted mid-line 200 of frame 3, released 10 cycles later:
   - All outputs 0 during reset.
   - No h_err or v_err at the first rises after release.
   - Relock after the 3rd post-reset vsync rise.
6. Hsync held low for 2000 cycles, then normal: period saturates at 1023, h_err once at the recovering rise, no spurious pix_valid before the following rise.
